// File: rtl/laser_spot_finder.sv
// laser_spot_finder
// Locates the laser spot in an RGB565 camera frame. Every assembled pixel is
// given an x/y position; pixels whose red channel reaches R_THRESH widen a
// bounding box and bump a saturating bright-pixel counter. At frame end the
// box centre ((min+max)>>1, no divider) and a found flag are published for
// the projector/game logic together with a one-cycle spot_valid pulse.

module laser_spot_finder #(
  parameter int unsigned H_ACTIVE   = 640,   // pixels per line
  parameter int unsigned V_ACTIVE   = 480,   // lines per frame
  parameter logic [4:0]  R_THRESH   = 5'd28, // red level that counts as bright
  parameter int unsigned MIN_PIXELS = 4      // bright pixels needed for a spot
) (
  input  logic        p_clock,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [15:0] pixel_data,
  input  logic        pixel_done,
  input  logic        frame_done,
  output logic [9:0]  spot_x,
  output logic [8:0]  spot_y,
  output logic [18:0] spot_count,
  output logic        spot_found,
  output logic        spot_valid,
  output logic        busy
);

  // Constants sized to the registers they are compared against.
  localparam logic [9:0]  X_LAST    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LIMIT   = 10'(V_ACTIVE);
  localparam logic [8:0]  Y_MAX     = 9'd511;
  localparam logic [18:0] COUNT_MAX = '1;
  localparam logic [18:0] MIN_COUNT = 19'(MIN_PIXELS);

  // Box reset values: an empty box has min above any max.
  localparam logic [9:0]  MIN_X_INIT = 10'd1023;
  localparam logic [8:0]  MIN_Y_INIT = 9'd511;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Scan position of the next pixel to arrive.
  logic [9:0]  x;
  logic [8:0]  y;

  // Running accumulators for the frame in progress.
  logic [18:0] count;
  logic [9:0]  min_x;
  logic [9:0]  max_x;
  logic [8:0]  min_y;
  logic [8:0]  max_y;

  // Per-cycle decode.
  logic        report;
  logic        clear;
  logic        accept;
  logic        bright;
  logic        in_frame;
  logic        hit;
  logic        found;
  logic [10:0] sum_x;
  logic [9:0]  sum_y;

  // Only the red channel decides brightness; green/blue are don't-care.
  logic        unused_pixel_bits;
  assign unused_pixel_bits = ^pixel_data[10:0];

  // A frame_start in any state restarts accumulation, so it always clears.
  // In ACCUM it also wins over a coincident pixel or frame_done: the old
  // frame is abandoned and must not leak into the new one or be reported.
  assign clear    = frame_start;
  assign accept   = (state == ACCUM) && pixel_done && !frame_start;
  assign bright   = (pixel_data[15:11] >= R_THRESH);
  assign in_frame = ({1'b0, y} < Y_LIMIT);
  assign hit      = accept && bright && in_frame;

  // Centre arithmetic uses one extra bit so min+max cannot wrap.
  assign found = (count >= MIN_COUNT);
  assign sum_x = {1'b0, min_x} + {1'b0, max_x};
  assign sum_y = {1'b0, min_y} + {1'b0, max_y};

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) so all registers update
  // from the same pre-edge values; blocking here would create order races.
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (frame_start) state_next = ACCUM;
      end
      ACCUM: begin
        if (frame_start)     state_next = ACCUM;
        else if (frame_done) state_next = REPORT;
      end
      REPORT: begin
        state_next = frame_start ? ACCUM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State-derived controls.
  always_comb begin
    busy   = (state == ACCUM);
    report = (state == REPORT);
  end

  // Scan position: raster order, x wraps at the line end, y saturates.
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x == X_LAST) begin
        x <= '0;
        if (y != Y_MAX) y <= y + 9'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  // Bright-pixel counter, saturating so huge spots never read as small ones.
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (hit && (count != COUNT_MAX)) begin
      count <= count + 19'd1;
    end
  end

  // Bounding box of bright pixels inside the active area.
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      min_x <= MIN_X_INIT;
      max_x <= '0;
      min_y <= MIN_Y_INIT;
      max_y <= '0;
    end else if (clear) begin
      min_x <= MIN_X_INIT;
      max_x <= '0;
      min_y <= MIN_Y_INIT;
      max_y <= '0;
    end else if (hit) begin
      if (x < min_x) min_x <= x;
      if (x > max_x) max_x <= x;
      if (y < min_y) min_y <= y;
      if (y > max_y) max_y <= y;
    end
  end

  // Published results: updated once per completed frame; the centre is only
  // refreshed when a spot was found, otherwise the last good centre holds.
  always_ff @(posedge p_clock or negedge reset_n) begin
    if (!reset_n) begin
      spot_x     <= '0;
      spot_y     <= '0;
      spot_count <= '0;
      spot_found <= 1'b0;
      spot_valid <= 1'b0;
    end else begin
      spot_valid <= report;
      if (report) begin
        spot_count <= count;
        spot_found <= found;
        if (found) begin
          spot_x <= sum_x[10:1];
          spot_y <= sum_y[9:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_laser_spot_finder.sv
// Self-checking bench for laser_spot_finder on a reduced 20x4 frame.
// Expected results come from a reference model that places the i-th pixel at
// (i mod H, i div H) and folds bright in-frame pixels into a count and box.

module tb_laser_spot_finder;

  localparam int H     = 20;
  localparam int V     = 4;
  localparam int RTH   = 28;
  localparam int MINPX = 4;

  logic        p_clock = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic [15:0] pixel_data;
  logic        pixel_done;
  logic        frame_done;
  logic [9:0]  spot_x;
  logic [8:0]  spot_y;
  logic [18:0] spot_count;
  logic        spot_found;
  logic        spot_valid;
  logic        busy;

  laser_spot_finder #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .R_THRESH  (5'd28),
    .MIN_PIXELS(MINPX)
  ) dut (
    .p_clock    (p_clock),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .pixel_data (pixel_data),
    .pixel_done (pixel_done),
    .frame_done (frame_done),
    .spot_x     (spot_x),
    .spot_y     (spot_y),
    .spot_count (spot_count),
    .spot_found (spot_found),
    .spot_valid (spot_valid),
    .busy       (busy)
  );

  always #5 p_clock = ~p_clock;

  int errors = 0;
  int checks = 0;

  // Every spot_valid high level seen mid-cycle is one pulse.
  int valid_pulses = 0;
  int exp_pulses   = 0;
  always @(negedge p_clock) if (spot_valid === 1'b1) valid_pulses++;

  // Reference model state: what the outputs should show after the last report.
  logic [15:0] pix_q[$];
  int exp_x = 0, exp_y = 0, exp_count = 0, exp_found = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge p_clock);
    #1;
  endtask

  task automatic idle_inputs();
    frame_start = 1'b0;
    pixel_done  = 1'b0;
    pixel_data  = 16'h0000;
    frame_done  = 1'b0;
  endtask

  function automatic logic [15:0] rand_pix(input int pct);
    logic [4:0]  r;
    logic [10:0] gb;
    gb = 11'($urandom);
    if (int'($urandom_range(0, 99)) < pct) r = 5'($urandom_range(28, 31));
    else                                   r = 5'($urandom_range(0, 27));
    return {r, gb};
  endfunction

  // Reference: fold the queued frame into count / box / centre.
  task automatic model_report();
    int cnt, mnx, mny, mxx, mxy;
    cnt = 0; mnx = 1023; mny = 511; mxx = 0; mxy = 0;
    for (int i = 0; i < pix_q.size(); i++) begin
      int px, py;
      px = i % H;
      py = i / H;
      if (py > 511) py = 511;
      if (py < V && int'(pix_q[i][15:11]) >= RTH) begin
        cnt++;
        if (px < mnx) mnx = px;
        if (px > mxx) mxx = px;
        if (py < mny) mny = py;
        if (py > mxy) mxy = py;
      end
    end
    if (cnt > 524287) cnt = 524287;
    exp_count = cnt;
    exp_found = (cnt >= MINPX) ? 1 : 0;
    if (exp_found != 0) begin
      exp_x = (mnx + mxx) / 2;
      exp_y = (mny + mxy) / 2;
    end
  endtask

  // Drive the queued frame, then check the report it produces.
  task automatic run_frame(input bit skip_start, input bit same_cycle_done,
                           input bit start_in_report, input int gap_pct);
    if (!skip_start) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
    end
    for (int i = 0; i < pix_q.size(); i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) step();
      pixel_done = 1'b1;
      pixel_data = pix_q[i];
      if (same_cycle_done && i == pix_q.size() - 1) frame_done = 1'b1;
      step();
      idle_inputs();
    end
    if (!same_cycle_done) begin
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
    end
    model_report();
    exp_pulses++;
    check("valid_not_early", 32'(spot_valid), 32'd0);
    if (start_in_report) frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("valid_pulse", 32'(spot_valid), 32'd1);
    check("spot_count",  32'(spot_count), 32'(exp_count));
    check("spot_found",  32'(spot_found), 32'(exp_found));
    check("spot_x",      32'(spot_x),     32'(exp_x));
    check("spot_y",      32'(spot_y),     32'(exp_y));
    check("busy_after_report", 32'(busy), 32'(start_in_report));
    if (!start_in_report) begin
      step();
      check("valid_one_cycle", 32'(spot_valid), 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();

    // Reset values.
    step();
    step();
    check("rst_x",     32'(spot_x),     32'd0);
    check("rst_y",     32'(spot_y),     32'd0);
    check("rst_count", 32'(spot_count), 32'd0);
    check("rst_found", 32'(spot_found), 32'd0);
    check("rst_valid", 32'(spot_valid), 32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    reset_n = 1'b1;
    step();

    // Directed frame: 4x2 block of full-red pixels at x=5..8, y=1..2.
    pix_q.delete();
    for (int i = 0; i < H * V; i++) begin
      if ((i % H) >= 5 && (i % H) <= 8 && (i / H) >= 1 && (i / H) <= 2) pix_q.push_back(16'hF800);
      else pix_q.push_back(16'h0000);
    end
    run_frame(1'b0, 1'b0, 1'b0, 0);
    check("dir_x",     32'(spot_x),     32'd6);
    check("dir_y",     32'(spot_y),     32'd1);
    check("dir_count", 32'(spot_count), 32'd8);
    check("dir_found", 32'(spot_found), 32'd1);

    // Stray pixel_done / frame_done in IDLE are ignored.
    for (int i = 0; i < 6; i++) begin
      pixel_done = 1'b1;
      pixel_data = 16'hF800;
      frame_done = (i % 2 == 1);
      step();
    end
    idle_inputs();
    step();
    step();
    check("stray_pulses", 32'(valid_pulses), 32'(exp_pulses));
    check("stray_busy",   32'(busy),         32'd0);
    check("stray_x",      32'(spot_x),       32'd6);
    check("stray_count",  32'(spot_count),   32'd8);

    // Threshold edge: ten red=27 pixels, three red=28 pixels.
    pix_q.delete();
    for (int i = 0; i < H * V; i++) pix_q.push_back(16'h0000);
    for (int k = 0; k < 13; k++) pix_q[k * 6] = (k < 10) ? 16'hD800 : 16'hE000;
    run_frame(1'b0, 1'b0, 1'b0, 10);
    check("thr_count", 32'(spot_count), 32'd3);
    check("thr_found", 32'(spot_found), 32'd0);
    check("thr_x",     32'(spot_x),     32'd6);
    check("thr_y",     32'(spot_y),     32'd1);

    // Last pixel (19,3) is bright and coincides with frame_done.
    pix_q.delete();
    for (int i = 0; i < H * V; i++) pix_q.push_back(16'h07FF);
    pix_q[0 * H + 10] = 16'hF800;
    pix_q[1 * H + 12] = 16'hF800;
    pix_q[2 * H + 15] = 16'hF800;
    pix_q[3 * H + 19] = 16'hF800;
    run_frame(1'b0, 1'b1, 1'b0, 0);
    check("edge_x",     32'(spot_x),     32'd14);
    check("edge_y",     32'(spot_y),     32'd1);
    check("edge_count", 32'(spot_count), 32'd4);

    // frame_start in the REPORT cycle chains straight into the next frame.
    pix_q.delete();
    for (int i = 0; i < H * V; i++) pix_q.push_back(rand_pix(20));
    run_frame(1'b0, 1'b0, 1'b1, 15);
    pix_q.delete();
    for (int i = 0; i < H * V; i++) pix_q.push_back(rand_pix(25));
    run_frame(1'b1, 1'b0, 1'b0, 15);

    // Abandoned frame: 30 bright pixels, then a restart.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      pixel_done = 1'b1;
      pixel_data = 16'hF800;
      step();
    end
    idle_inputs();
    step();
    check("abandon_no_pulse", 32'(valid_pulses), 32'(exp_pulses));
    pix_q.delete();
    for (int i = 0; i < H * V; i++) pix_q.push_back(rand_pix(10));
    run_frame(1'b0, 1'b0, 1'b0, 0);

    // Overflow: 100 bright pixels past the last active line are ignored.
    pix_q.delete();
    for (int i = 0; i < H * V; i++) pix_q.push_back(rand_pix(8));
    for (int i = 0; i < 100; i++) pix_q.push_back(16'hF800);
    run_frame(1'b0, 1'b0, 1'b0, 5);

    // Randomised frames with gaps and random frame_done alignment.
    for (int f = 0; f < 8; f++) begin
      int n;
      n = int'($urandom_range(1, H * V + 40));
      pix_q.delete();
      for (int i = 0; i < n; i++) pix_q.push_back(rand_pix(int'($urandom_range(2, 40))));
      run_frame(1'b0, 1'($urandom_range(0, 1)), 1'b0, 20);
    end
    check("random_pulses", 32'(valid_pulses), 32'(exp_pulses));

    // Asynchronous reset between edges in the middle of a frame.
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      pixel_done = 1'b1;
      pixel_data = rand_pix(50);
      step();
    end
    check("pre_reset_busy", 32'(busy), 32'd1);
    #3;
    reset_n = 1'b0;
    idle_inputs();
    #1;
    check("async_busy",  32'(busy),       32'd0);
    check("async_x",     32'(spot_x),     32'd0);
    check("async_y",     32'(spot_y),     32'd0);
    check("async_count", 32'(spot_count), 32'd0);
    check("async_found", 32'(spot_found), 32'd0);
    check("async_valid", 32'(spot_valid), 32'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pixel_done = 1'b1;
      pixel_data = 16'hF800;
      frame_done = (i == 4);
      step();
    end
    idle_inputs();
    step();
    step();
    check("post_reset_pulses", 32'(valid_pulses), 32'(exp_pulses));
    check("post_reset_busy",   32'(busy),         32'd0);
    check("post_reset_count",  32'(spot_count),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
